// File: rtl/i2s_tx.sv
// i2s_tx: serializes 16-bit stereo PCM pairs into a standard I2S stream.
// All I2S clocks are derived from clk; one L/R pair is taken per frame through a holding register.
module i2s_tx #(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        underrun
);
  localparam logic [7:0] DIV_MAX = 8'(BCLK_DIV - 1);
  logic [7:0] div_cnt;
  logic [4:0] bit_cnt, bit_nxt;
  logic [15:0] hold_l, hold_r;
  logic [31:0] shreg;
  logic hold_full, fall, load, accept;
  assign fall = div_cnt == DIV_MAX && i2s_bclk;
  assign bit_nxt = bit_cnt + 5'd1;
  assign load = fall && bit_nxt == 5'd0;
  assign accept = sample_valid && !hold_full;
  assign sample_ready = !hold_full;
  // lrclk leads each channel's MSB by one bclk, hence the 15..30 window
  always_ff @(posedge clk)
    if (reset) begin
      div_cnt <= 8'd0;
      bit_cnt <= 5'd31;
      i2s_bclk <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      underrun <= 1'b0;
      shreg <= 32'd0;
      hold_l <= 16'd0;
      hold_r <= 16'd0;
      hold_full <= 1'b0;
    end else begin
      div_cnt <= div_cnt == DIV_MAX ? 8'd0 : div_cnt + 8'd1;
      if (div_cnt == DIV_MAX) i2s_bclk <= !i2s_bclk;
      underrun <= load && !hold_full;
      if (fall) begin
        bit_cnt <= bit_nxt;
        i2s_lrclk <= bit_nxt >= 5'd15 && bit_nxt != 5'd31;
        shreg <= load ? {hold_l, hold_r} : shreg << 1;
        i2s_sdata <= load ? hold_l[15] : shreg[30];
      end
      if (accept) begin
        hold_l <= sample_l;
        hold_r <= sample_r;
        hold_full <= 1'b1;
      end else if (load) hold_full <= 1'b0;
    end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: runs three i2s_tx instances (BCLK_DIV 4, 1, 256) against a cycle-count frame model.
module tb_i2s_tx;
  logic clk = 0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int D = g == 0 ? 4 : g == 1 ? 1 : 256;
    localparam int NB = D > 64 ? 0 : 2;
    logic rst = 1, valid = 0, ready, bclk, lr, sd, und;
    logic [15:0] sl = 0, sr = 0;
    bit done = 0;
    int c = 0;
    logic full = 0;
    logic [15:0] hl = 0, hr = 0;
    logic [31:0] fr = 0;
    i2s_tx #(.BCLK_DIV(D)) dut (
      .clk(clk), .reset(rst), .sample_l(sl), .sample_r(sr), .sample_valid(valid),
      .sample_ready(ready), .i2s_bclk(bclk), .i2s_lrclk(lr), .i2s_sdata(sd), .underrun(und)
    );
    // c counts clk edges since reset release; frame n bit k is emitted at edge 2*D*(32n+k+1)
    task automatic step(input logic r, input logic v);
      logic acc, load, eu;
      int k;
      acc = 0;
      eu = 0;
      @(negedge clk);
      rst = r;
      valid = v;
      if (r) begin
        c = 0; full = 0; hl = 0; hr = 0; fr = 0;
      end else begin
        c++;
        acc = v && !full;
        load = c % (64 * D) == 2 * D;
        eu = load && !full;
        if (load) fr = {hl, hr};
        if (acc) begin
          hl = sl; hr = sr; full = 1;
        end else if (load) full = 0;
      end
      @(posedge clk);
      #1;
      k = c < 2 * D ? -1 : (c / (2 * D) - 1) % 32;
      check($sformatf("D%0d c%0d bclk", D, c), 32'(bclk), 32'((c / D) % 2));
      check($sformatf("D%0d c%0d sdata", D, c), 32'(sd), k < 0 ? 32'd0 : 32'(fr[31 - k]));
      check($sformatf("D%0d c%0d lrclk", D, c), 32'(lr), 32'(k >= 15 && k <= 30));
      check($sformatf("D%0d c%0d underrun", D, c), 32'(und), 32'(eu));
      check($sformatf("D%0d c%0d ready", D, c), 32'(ready), 32'(!full));
      if (acc) begin
        sl = 16'($urandom);
        sr = 16'($urandom);
      end
    endtask
    initial begin
      repeat (3) step(1, 0);
      sl = 16'hA5C3;
      sr = 16'h0F01;
      step(0, 1);
      while (c < 66 * D + 4) step(0, 0);
      for (int i = 0; i < NB * 64 * D; i++) step(0, 1);
      for (int i = 0; i < NB * 64 * D; i++) step(0, ($urandom % (48 * D)) == 0);
      for (int i = 0; i < NB * 64 * D; i++) step(0, (c + 1) % (64 * D) == 2 * D);
      while (c < 2 * D || (c / (2 * D) - 1) % 32 != 20) step(0, 0);
      step(1, 0);
      while (c < 66 * D + 2) step(0, 0);
      done = 1;
    end
  end
  initial begin
    fork
      wait (u[0].done && u[1].done && u[2].done);
      repeat (90000) @(posedge clk);
    join_any
    check("all_done", {29'd0, u[0].done, u[1].done, u[2].done}, 32'd7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
